// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   tx_state_e      : frame sequencer state encoding
//   OVS_DEFAULT     : default oversample ticks per serial bit
//   OVS_MIN/OVS_MAX : legal oversample range (tick counter is 4 bits)
//   STOP_BITS_MIN/MAX : legal stop-bit counts
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam int OVS_DEFAULT   = 16;
    localparam int OVS_MIN       = 2;
    localparam int OVS_MAX       = 16;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer -- serialises one byte per frame onto txd:
//   start(0), 7 or 8 data bits LSB first, optional parity, STOP_BITS stop(1).
// Each bit lasts OVS baud_en ticks. txd is registered and idles high.
//
// Build option: define UART_TX_PARITY_EN to compile in the parity state and
// parity generation. Without it parity_en/odd_n_even are accepted but ignored.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   baud_en       one-clk oversample tick
//   tx_data       byte to send (bit 7 dropped when bit8=0)
//   tx_valid      tx_data valid; held by the source until accepted
//   tx_ready      sequencer idle and able to accept
//   bit8          1 = 8 data bits, 0 = 7 data bits
//   parity_en     append a parity bit
//   odd_n_even    1 = odd parity, 0 = even parity
//   txd           serial output
//   tx_busy       frame in progress
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int OVS       = OVS_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [3:0] TICK_LAST = 4'(OVS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e   state, state_d;
    logic [3:0]  tick, tick_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        stop_idx, stop_idx_d;
    logic [7:0]  data_q, data_d;
    logic        bit8_q, bit8_d;
    logic        txd_d, ready_d, busy_d;

    logic accept, bit_end, last_data, last_stop;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic odd_q, odd_d;
    logic parity_bit;

    // Parity covers only the bits actually sent.
    assign parity_bit = (^(data_q & (bit8_q ? 8'hFF : 8'h7F))) ^ odd_q;
`else
    logic unused_parity_inputs;
    assign unused_parity_inputs = parity_en ^ odd_n_even;
`endif

    assign accept    = (state == S_IDLE) && tx_valid && tx_ready;
    // A bit ends on its OVS-th tick; the FSM advances on that same edge.
    assign bit_end   = baud_en && (tick == TICK_LAST);
    assign last_data = (bit_idx == (bit8_q ? 3'd7 : 3'd6));
    assign last_stop = (stop_idx == STOP_LAST);

    // State register (all sequential state lives here)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            data_q   <= '0;
            bit8_q   <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            data_q   <= data_d;
            bit8_q   <= bit8_d;
            txd      <= txd_d;
            tx_ready <= ready_d;
            tx_busy  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q <= par_en_d;
            odd_q    <= odd_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state;
        tick_d     = tick;
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        data_d     = data_q;
        bit8_d     = bit8_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        odd_d      = odd_q;
`endif

        // Tick counter: cleared on accept, held in idle, wraps at bit end.
        if (accept)
            tick_d = '0;
        else if (state != S_IDLE && baud_en)
            tick_d = bit_end ? 4'd0 : tick + 4'd1;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    data_d     = tx_data;
                    bit8_d     = bit8;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = parity_en;
                    odd_d      = odd_n_even;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop)
                        state_d = S_IDLE;
                    else
                        stop_idx_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: registered outputs take the level of the state being
    // entered, so txd changes on the same edge as the state.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        txd_d   = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_bit;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Randomised self-checking bench for uart_tx_sequencer.
// Two instances: u_a (OVS=16, 1 stop bit) and u_b (OVS=16, 2 stop bits);
// 'sel' routes tx_valid to one of them and picks which outputs are observed.
// The reference model builds each frame as a list of line levels and expects
// every level to be held for OVS baud ticks after the accept edge.
module tb_uart_tx_sequencer;

    localparam int OVS = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       sel = 1'b0;

    logic valid_a, valid_b;
    logic txd_a, ready_a, busy_a, txd_b, ready_b, busy_b;
    logic txd_o, ready_o, busy_o;

    assign valid_a = tx_valid & ~sel;
    assign valid_b = tx_valid & sel;
    assign txd_o   = sel ? txd_b   : txd_a;
    assign ready_o = sel ? ready_b : ready_a;
    assign busy_o  = sel ? busy_b  : busy_a;

    uart_tx_sequencer #(.OVS(OVS), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(valid_a), .tx_ready(ready_a), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even),
        .txd(txd_a), .tx_busy(busy_a)
    );

    uart_tx_sequencer #(.OVS(OVS), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(valid_b), .tx_ready(ready_b), .bit8(bit8),
        .parity_en(parity_en), .odd_n_even(odd_n_even),
        .txd(txd_b), .tx_busy(busy_b)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int exp_bits[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: line levels in transmission order.
    task automatic build_frame(input logic [7:0] d, input bit b8, input bit pen,
                               input bit odd, input int stops);
        int nd, ones, b;
        exp_bits.delete();
        exp_bits.push_back(0);
        nd   = b8 ? 8 : 7;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            b = int'((d >> i) & 8'd1);
            exp_bits.push_back(b);
            ones += b;
        end
        if (PAR_BUILD && pen)
            exp_bits.push_back((ones + (odd ? 1 : 0)) % 2);
        for (int i = 0; i < stops; i++)
            exp_bits.push_back(1);
    endtask

    // Drive a byte so that the next rising edge accepts it.
    task automatic start_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd);
        build_frame(d, b8, pen, odd, sel ? 2 : 1);
        @(negedge clk);
        chk("ready_before_accept", 32'(ready_o), 32'd1);
        tx_data    = d;
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        tx_valid   = 1'b1;
        baud_en    = 1'($urandom_range(0, 1));  // tick on the accept edge must not count
        @(posedge clk);
    endtask

    // Follow the frame from the accept edge. div>0: baud every div-th clk;
    // div=0: random baud with a guaranteed tick at least every 5 clks.
    task automatic play_frame(input int div, input bit hold_next, input logic [7:0] nd,
                              input bit scramble, input int abort_bit);
        int k, ticks;
        k = 0;
        for (int bi = 0; bi < exp_bits.size(); bi++) begin
            ticks = 0;
            while (ticks < OVS) begin
                @(negedge clk);
                if (bi == abort_bit && ticks == OVS / 2) return;
                chk("frame_line", 32'({txd_o, busy_o, ready_o}),
                    32'({1'(exp_bits[bi]), 2'b10}));
                if (k == 0) begin
                    tx_valid = hold_next;
                    if (hold_next) tx_data = nd;
                    if (scramble) begin
                        tx_data    = 8'($urandom);
                        bit8       = 1'($urandom);
                        parity_en  = 1'($urandom);
                        odd_n_even = 1'($urandom);
                    end
                end
                if (div == 0)
                    baud_en = ($urandom_range(0, 3) == 0) || (k % 5 == 4);
                else
                    baud_en = (k % div == div - 1);
                @(posedge clk);
                k++;
                if (baud_en) ticks++;
            end
        end
        @(negedge clk);
        baud_en = 1'b0;
        chk("frame_end_idle", 32'({txd_o, busy_o, ready_o}), 32'b101);
        if (div > 0)
            chk("frame_len_clk", 32'(k), 32'(exp_bits.size() * OVS * div));
    endtask

    initial begin
        logic [7:0] d;
        int div;
        bit scr;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state_a", 32'({txd_a, busy_a, ready_a}), 32'b100);
        chk("rst_state_b", 32'({txd_b, busy_b, ready_b}), 32'b100);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'({txd_o, busy_o, ready_o}), 32'b101);

        // 0x55 8N1, baud every clk: 160 clk frame
        start_frame(8'h55, 1'b1, 1'b0, 1'b0);
        play_frame(1, 1'b0, 8'h00, 1'b0, -1);

        // 0x07 8 bits even parity; 0x7F 7 bits odd parity
        start_frame(8'h07, 1'b1, 1'b1, 1'b0);
        play_frame(1, 1'b0, 8'h00, 1'b0, -1);
        start_frame(8'h7F, 1'b0, 1'b1, 1'b1);
        play_frame(2, 1'b0, 8'h00, 1'b0, -1);

        // Back-to-back with tx_valid held: 0x01 then 0x80
        start_frame(8'h01, 1'b1, 1'b0, 1'b0);
        play_frame(2, 1'b1, 8'h80, 1'b0, -1);
        build_frame(8'h80, 1'b1, 1'b0, 1'b0, 1);
        play_frame(2, 1'b0, 8'h00, 1'b0, -1);

        // Inputs toggled mid-frame must not alter it
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        play_frame(1, 1'b0, 8'h00, 1'b1, -1);

        // Reset during data bit 3, then a clean 0x3C frame
        start_frame(8'hC6, 1'b1, 1'b0, 1'b0);
        play_frame(1, 1'b0, 8'h00, 1'b0, 4);
        rst = 1'b1;
        #1;
        chk("rst_mid_frame", 32'({txd_o, busy_o, ready_o}), 32'b100);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        baud_en = 1'b0;
        @(negedge clk);
        chk("ready_after_rst2", 32'({txd_o, busy_o, ready_o}), 32'b101);
        start_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        play_frame(1, 1'b0, 8'h00, 1'b0, -1);

        // Random frames on the 1-stop instance
        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom);
            div = (n % 4 == 3) ? 0 : (1 << $urandom_range(0, 2));
            scr = 1'($urandom);
            start_frame(d, 1'($urandom), 1'($urandom), 1'($urandom));
            play_frame(div, 1'b0, 8'h00, scr, -1);
        end

        // 2-stop instance: 0xA3 with baud every 4th clk (64 clk per bit)
        @(negedge clk);
        sel = 1'b1;
        start_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        play_frame(4, 1'b0, 8'h00, 1'b0, -1);
        for (int n = 0; n < 3; n++) begin
            d = 8'($urandom);
            start_frame(d, 1'($urandom), 1'($urandom), 1'($urandom));
            play_frame(n == 1 ? 0 : 1, 1'b0, 8'h00, 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter OVS, default 16: number of BAUD_EN ticks per serial bit, legal range 2..16.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits per frame, legal values 1 or 2.
REQ-003 CLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 BAUD_EN  in  1  one-CLK oversample tick from the UART clock generator (OVS ticks per bit).
REQ-006 TX_DATA  in  8  byte to transmit.
REQ-007 TX_VALID  in  1  TX_DATA is valid.
REQ-008 TX_READY  out  1  the sequencer can accept a byte.
REQ-009 BIT8  in  1  1 = 8 data bits; 0 = 7 data bits, which sends TX_DATA[6:0].
REQ-010 PARITY_EN  in  1  append a parity bit.
REQ-011 ODD_N_EVEN  in  1  1 = odd parity; 0 = even parity.
REQ-012 TXD  out  1  serial line output; idles high.
REQ-013 TX_BUSY  out  1  a frame is in progress.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 Accept SHALL occur on a CLK edge where TX_VALID=1, TX_READY=1 and the state is IDLE.
REQ-016 On accept, the block SHALL capture TX_DATA, BIT8, PARITY_EN and ODD_N_EVEN; changes to these inputs during the frame SHALL have no effect.
REQ-017 On accept, the block SHALL enter START; TX_READY SHALL go to 0 and TX_BUSY to 1 on the next edge.
REQ-018 TXD SHALL be registered and SHALL equal the current bit's level from the edge that enters that bit's state.
REQ-019 The tick counter (4 bits) SHALL clear on accept and increment only on BAUD_EN.
REQ-020 Each bit SHALL end on the OVS-th BAUD_EN tick; the counter SHALL then wrap to 0 and the FSM SHALL advance on that same edge.
REQ-021 The bit order SHALL be: start (0); data LSB first (7 or 8 bits, counted by a 3-bit index); parity if enabled; STOP_BITS stop bits (1).
REQ-022 The parity bit SHALL be the XOR of the sent data bits, XORed with ODD_N_EVEN.
REQ-023 When the last stop bit ends, the FSM SHALL go to IDLE, with TX_READY=1 and TX_BUSY=0 on the same edge.
REQ-024 In IDLE with TX_VALID held at 1, the next frame SHALL be accepted on the following edge, giving back-to-back frames with at least one idle-high CLK between stop and start.
REQ-025 If BAUD_EN is not asserted, the FSM SHALL hold its state and TXD SHALL be stable.
REQ-026 TX_VALID=1 outside IDLE SHALL be ignored, and no data SHALL be lost; the source holds TX_VALID until accept.

Reset
REQ-027 While RESET=1, the outputs SHALL be TXD=1, TX_READY=0 and TX_BUSY=0, with state IDLE and all counters at 0.
REQ-028 TX_READY SHALL rise on the first CLK edge after RESET deasserts.
REQ-029 RESET asserted mid-frame SHALL drive TXD=1 immediately and abandon the frame; no partial frame SHALL resume.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: the PARITY state and parity logic SHALL be compiled in and SHALL behave per REQ-021 and REQ-022.
REQ-031 Macro UART_TX_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent; PARITY_EN and ODD_N_EVEN SHALL remain as ports but SHALL be ignored, and frames SHALL never carry parity.

Structure
REQ-032 The shared package uart_pkg SHALL hold the FSM state encoding, the default OVS value and the STOP_BITS legal-value constants.
REQ-033 The block SHALL be a single module with no sub-module; parity is an inline XOR reduction and the tick counter is local.

Verification
REQ-034 OVS=16, BAUD_EN=1 every cycle, 8N1, byte 0x55: TXD SHALL be 0,1,0,1,0,1,0,1,0,1, each level held 16 CLK; TX_READY SHALL return 160 CLK after accept.
REQ-035 8 data bits, even parity, byte 0x07: the parity bit SHALL be 1; 7 data bits, odd parity, byte 0x7F: the 7 data bits SHALL be 1 and the parity bit SHALL be 0; each frame SHALL be 11 and 10 bits long respectively.
REQ-036 BAUD_EN every 4th CLK, STOP_BITS=2, byte 0xA3: each bit SHALL last 64 CLK and the frame SHALL last 11 bit times.
REQ-037 TX_VALID held at 1 with bytes 0x01 then 0x80: two complete frames SHALL be sent, the second accepted 1 CLK after TX_READY rises, and no byte SHALL be dropped.
REQ-038 RESET pulsed during data bit 3: TXD SHALL be 1 immediately and TX_READY SHALL be 1 one CLK after release; the next byte 0x3C SHALL be sent as a clean full frame.
REQ-039 TX_DATA, BIT8 and PARITY_EN toggled mid-frame: the frame SHALL be unchanged; a build without UART_TX_PARITY_EN and PARITY_EN=1 SHALL send 10-bit 8N1 frames.
